// File: rtl/uart_sample_framer.sv
// Purpose : buffers 16-bit audio samples in a small FIFO and serializes each one as a
//           framed byte sequence (sync, hi, lo[, checksum]) into a byte-wide UART TX.
// Latency : strobe at edge N -> pushed after N, popped at N+1, sync byte pulse after N+2.
// Backpressure: waits on uart_busy_in before each byte. Samples arriving while the FIFO
//           is full are dropped and counted.
//
// Ports:
//   clk_in, rst_in           - clock, asynchronous active-high reset
//   sample_in/_valid_in      - 16-bit sample and single-cycle strobe from the I2S receiver
//   uart_busy_in             - transmitter busy flag
//   byte_out/byte_valid_out  - registered byte and one-cycle trigger to the transmitter
//   fill_out                 - FIFO occupancy (excludes the sample held in the frame register)
//   overflow_out             - sticky drop flag; drop_count_out - saturating drop counter
//
// Build option: define UART_FRAMER_CHECKSUM_EN to append a checksum byte
// (SYNC_BYTE ^ hi ^ lo), making frames 4 bytes long instead of 3.

module uart_sample_framer #(
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid_in,
    input  logic                     uart_busy_in,
    output logic [7:0]               byte_out,
    output logic                     byte_valid_out,
    output logic [$clog2(DEPTH):0]   fill_out,
    output logic                     overflow_out,
    output logic [15:0]              drop_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_FRAMER_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    state_t        state_q, state_d;
    logic [15:0]   frame_q, frame_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic [7:0]    frame_byte;

    // ------------------------------------------------------------------
    // FIFO control. Full is judged on the registered count, so a sample
    // arriving while full is dropped even if the FSM pops in that cycle.
    // ------------------------------------------------------------------
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = sample_valid_in && !full;
    assign drop  = sample_valid_in && full;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Storage has no reset; the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // ------------------------------------------------------------------
    // Frame byte selection
    // ------------------------------------------------------------------
    always_comb begin
        frame_byte = SYNC_BYTE;
        case (idx_q)
            2'd0:    frame_byte = SYNC_BYTE;
            2'd1:    frame_byte = frame_q[15:8];
            2'd2:    frame_byte = frame_q[7:0];
`ifdef UART_FRAMER_CHECKSUM_EN
            2'd3:    frame_byte = SYNC_BYTE ^ frame_q[15:8] ^ frame_q[7:0];
`endif
            default: frame_byte = SYNC_BYTE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty)        state_d = ST_SEND;
            ST_SEND: if (!uart_busy_in) state_d = ST_HOLD;
            // HOLD spans the cycle in which the transmitter registers our
            // trigger and raises busy, so SEND never sees a stale busy=0.
            ST_HOLD: state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_SEND;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs and datapath next-state
    always_comb begin
        pop        = 1'b0;
        frame_d    = frame_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                end
            end
            ST_SEND: begin
                if (!uart_busy_in) begin
                    byte_d     = frame_byte;
                    byte_vld_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            frame_q    <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    assign byte_out       = byte_q;
    assign byte_valid_out = byte_vld_q;
    assign fill_out       = count_q;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_cnt_q;

endmodule
